// File: rtl/alu_result_stage.sv
// Elastic registered output stage behind the 8-bit ALU: small FIFO, status flags, sticky divide-by-zero error.
// Optional build macro RESULT_STAGE_PERF_EN adds saturating pop/stall performance counters.
module alu_result_stage #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              carry_out,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] operand_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic              res_neg,
  output logic [SEL_W-1:0]  res_op,
  output logic              res_div0,
  output logic              err_div0,
`ifdef RESULT_STAGE_PERF_EN
  output logic [15:0]       perf_results,
  output logic [15:0]       perf_stalls,
`endif
  input  logic              err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(3);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0]  op;
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              zero;
    logic              neg;
    logic              div0;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            hold_q, hold_d;
  entry_t            in_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push, pop;

  assign in_ready  = (cnt_q != CNT_FULL);
  assign res_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = res_valid && res_ready;

  // Build the stored entry; a divide by zero is reported as all-ones data.
  always_comb begin
    in_entry       = '0;
    in_entry.op    = alu_sel;
    in_entry.div0  = (alu_sel == OP_DIV) && (operand_b == '0);
    in_entry.data  = in_entry.div0 ? '1 : alu_out;
    in_entry.carry = (alu_sel == OP_ADD) ? carry_out : 1'b0;
    in_entry.zero  = (in_entry.data == '0);
    in_entry.neg   = in_entry.data[DATA_W-1];
  end

  // NOTE: the storage array has no reset; it is only ever read while count > 0,
  // and the empty case is served from the reset-cleared hold register instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Set has priority over clear so a divide-by-zero is never lost.
  always_comb begin
    err_d = err_q;
    if (push && in_entry.div0) err_d = 1'b1;
    else if (err_clr)          err_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  assign head      = res_valid ? mem_q[rd_ptr_q] : hold_q;
  assign res_data  = head.data;
  assign res_carry = head.carry;
  assign res_zero  = head.zero;
  assign res_neg   = head.neg;
  assign res_op    = head.op;
  assign res_div0  = head.div0;
  assign err_div0  = err_q;

`ifdef RESULT_STAGE_PERF_EN
  logic [15:0] perf_results_q, perf_results_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_results_d = perf_results_q;
    perf_stalls_d  = perf_stalls_q;
    if (pop && (perf_results_q != 16'hFFFF))
      perf_results_d = perf_results_q + 16'd1;
    if (in_valid && !in_ready && (perf_stalls_q != 16'hFFFF))
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_results_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_results_q <= perf_results_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_results = perf_results_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered, elastic output stage directly downstream of the 8-bit combinational ALU.
- Captures ALU_Out, CarryOut and the selected opcode through a valid/ready handshake into a small FIFO.
- Derives status flags and a sticky divide-by-zero error.
- Presents the results to the writeback consumer with its own valid/ready handshake, decoupling the ALU from consumer stalls.

Parameters:
- DATA_W, 8, ALU result width.
- SEL_W, 4, opcode width.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a valid ALU result this cycle.
- in_ready  output  1  stage can accept; equals "FIFO not full".
- alu_out  input  DATA_W  ALU result (ALU_Out).
- carry_out  input  1  ALU carry (CarryOut).
- alu_sel  input  SEL_W  opcode that produced alu_out.
- operand_b  input  DATA_W  B operand, used only for divide-by-zero detection.
- res_valid  output  1  head entry valid; equals "FIFO not empty".
- res_ready  input  1  consumer accepts the head entry.
- res_data  output  DATA_W  head result.
- res_carry  output  1  head carry; forced to 0 unless opcode 4'b0000.
- res_zero  output  1  head result == 0.
- res_neg  output  1  head result MSB.
- res_op  output  SEL_W  head opcode.
- res_div0  output  1  head entry came from a divide with B == 0.
- err_div0  output  1  sticky divide-by-zero error.
- err_clr  input  1  clears err_div0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - read/write pointers and count = 0; err_div0 = 0.
  - All res_* outputs = 0; res_valid = 0; in_ready = 1.
  - Reset mid-operation discards all stored entries.
- Push: occurs when in_valid && in_ready.
  - Entry stores {alu_sel, data, carry, zero, neg, div0}.
  - div0 = (alu_sel == 4'b0011) && (operand_b == 0). In that case the stored data is forced to all-ones (8'hFF), zero = 0, neg = 1.
  - carry is stored as carry_out only when alu_sel == 4'b0000; otherwise 0.
  - zero/neg are computed from the stored data value, after any forcing.
- Pop: occurs when res_valid && res_ready. The head advances and the next entry appears on the next cycle.
- Latency: an entry accepted in cycle N is visible on res_* with res_valid = 1 in cycle N+1. No combinational path from in_* to res_*.
- in_ready depends only on the FIFO count; it does not depend on res_ready, so there is no combinational ready path. When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Empty: res_valid = 0. res_* hold the last popped values; the consumer must ignore them.
- in_valid while full: no push. Upstream must hold its data; in_valid, alu_out, alu_sel and operand_b must stay stable until accepted.
- Pop while empty: ignored.
- err_div0:
  - Set on the cycle after a push with div0 = 1.
  - Cleared by err_clr.
  - If a set and err_clr occur in the same cycle, set wins.

Optional Feature:
- Macro RESULT_STAGE_PERF_EN.
- Defined: adds outputs perf_results[15:0] and perf_stalls[15:0], both reset to 0.
  - perf_results increments on each pop.
  - perf_stalls increments each cycle with in_valid && !in_ready.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push alu_out=8'h2A, alu_sel=0000, carry_out=1 with res_ready=1 → next cycle res_valid=1, res_data=8'h2A, res_carry=1, res_zero=0, res_neg=0; the following cycle res_valid=0.
- Hold res_ready=0 and push 3 results (8'h01, 8'h00, 8'h80) with DEPTH=2 → in_ready drops to 0 after the 2nd push and the 3rd is held. Raise res_ready → outputs appear in order 8'h01, then 8'h00 (res_zero=1), then 8'h80 (res_neg=1).
- Push alu_sel=0011, operand_b=0 → res_data=8'hFF, res_div0=1, res_carry=0, and err_div0=1 one cycle after the push. Pulse err_clr → err_div0=0. Assert err_clr in the same cycle as a new div0 push → err_div0 stays 1.
- Push alu_sel=0001 with carry_out=1 → res_carry=0.
- Continuous in_valid and res_ready for 10 cycles with incrementing data 0..9 → one result per cycle, in order, with 1-cycle latency and no bubbles across pointer wrap.
- Assert rst_n=0 with 2 entries stored → res_valid=0 and in_ready=1 immediately, err_div0=0. With RESULT_STAGE_PERF_EN: perf_results and perf_stalls return to 0, and perf_stalls counts exactly the full-stall cycles in the previous scenario.
